// File: rtl/tj4_pc_seq_if.sv
// Sequencer bus: program ROM port, 74HC161-style PC counter controls and ALU strobe.
// The sequencer uses the master modport; the counter/ROM/ALU side uses slave.
interface tj4_pc_seq_if #(
   parameter int unsigned OP_W  = 4,
   parameter int unsigned IMM_W = 4
);
   logic [IMM_W-1:0]      pc_q;
   logic [OP_W+IMM_W-1:0] rom_data;
   logic                  zf;
   logic                  cf;
   logic [IMM_W-1:0]      rom_addr;
   logic                  pc_pen;
   logic                  pc_cep;
   logic                  pc_cet;
   logic [IMM_W-1:0]      pc_di;
   logic                  alu_we;
   logic [OP_W-1:0]       alu_op;
   logic [IMM_W-1:0]      alu_imm;
   logic                  halted;

   modport master (
      input  pc_q, rom_data, zf, cf,
      output rom_addr, pc_pen, pc_cep, pc_cet, pc_di, alu_we, alu_op, alu_imm, halted
   );

   modport slave (
      output pc_q, rom_data, zf, cf,
      input  rom_addr, pc_pen, pc_cep, pc_cet, pc_di, alu_we, alu_op, alu_imm, halted
   );
endinterface

// File: rtl/tj4_pc_seq.sv
// Fetch/execute sequencer driving a loadable 4-bit PC counter; two cycles per instruction.
// Optional single-step gating of FETCH->EXEC on a rising edge of 'step': define TJ_SEQ_STEP_EN.
module tj4_pc_seq #(
   parameter int unsigned OP_W  = 4,
   parameter int unsigned IMM_W = 4
) (
   input  logic CP,
   input  logic MRn,
`ifdef TJ_SEQ_STEP_EN
   input  logic step,
`endif
   tj4_pc_seq_if.master bus
);
   localparam int unsigned IR_W = OP_W + IMM_W;

   localparam logic [1:0] S_RST   = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_EXEC  = 2'b10;
   localparam logic [1:0] S_HALT  = 2'b11;

   localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(1);
   localparam logic [OP_W-1:0] OP_JZ  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JNZ = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JC  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_HLT = OP_W'(5);

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [IR_W-1:0]  ir;
   logic             ir_ld;
   logic             go;
   logic [OP_W-1:0]  ir_op;
   logic [IMM_W-1:0] ir_imm;

   assign ir_op  = ir[IR_W-1:IMM_W];
   assign ir_imm = ir[IMM_W-1:0];

   assign bus.rom_addr = bus.pc_q;
   assign bus.pc_cet   = 1'b1;

`ifdef TJ_SEQ_STEP_EN
   logic step_q;

   // Previous step level for rising-edge detection
   always_ff @(posedge CP or negedge MRn) begin
      if (!MRn) step_q <= 1'b0;
      else      step_q <= step;
   end

   assign go = step & ~step_q;
`else
   assign go = 1'b1;
`endif

   always_ff @(posedge CP or negedge MRn) begin
      if (!MRn) begin
         state <= S_RST;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if (ir_ld) ir <= bus.rom_data;
      end
   end

   // Next state and counter/ALU control decode
   always_comb begin
      state_nx    = state;
      ir_ld       = 1'b0;
      bus.pc_pen  = 1'b1;
      bus.pc_cep  = 1'b0;
      bus.pc_di   = '0;
      bus.alu_we  = 1'b0;
      bus.alu_op  = '0;
      bus.alu_imm = '0;
      bus.halted  = 1'b0;

      case (state)
         S_RST: state_nx = S_FETCH;
         S_FETCH: begin
            if (go) begin
               state_nx = S_EXEC;
               ir_ld    = 1'b1;
            end
         end
         S_EXEC: begin
            state_nx  = S_FETCH;
            bus.pc_di = ir_imm;
            case (ir_op)
               OP_NOP: bus.pc_cep = 1'b1;
               OP_JMP: bus.pc_pen = 1'b0;
               OP_JZ: begin
                  if (bus.zf) bus.pc_pen = 1'b0;
                  else        bus.pc_cep = 1'b1;
               end
               OP_JNZ: begin
                  if (!bus.zf) bus.pc_pen = 1'b0;
                  else         bus.pc_cep = 1'b1;
               end
               OP_JC: begin
                  if (bus.cf) bus.pc_pen = 1'b0;
                  else        bus.pc_cep = 1'b1;
               end
               OP_HLT: state_nx = S_HALT;
               default: begin
                  bus.alu_we  = 1'b1;
                  bus.alu_op  = ir_op;
                  bus.alu_imm = ir_imm;
                  bus.pc_cep  = 1'b1;
               end
            endcase
         end
         S_HALT: bus.halted = 1'b1;
         default: state_nx = S_RST;
      endcase
   end
endmodule

// File: tb/tb_tj4_pc_seq.sv
// Directed bench for tj4_pc_seq with a behavioural 74HC161 PC counter and a 16-byte ROM.
// Step-gating checks run only when TJ_SEQ_STEP_EN is defined.
module tb_tj4_pc_seq;
   logic       CP;
   logic       MRn;
   logic       zf;
   logic       cf;
   logic [7:0] rom [16];
   logic [3:0] pc;
   int         errors;
   int         checks;
`ifdef TJ_SEQ_STEP_EN
   logic       step;
`endif

   tj4_pc_seq_if bus ();

   tj4_pc_seq dut (
      .CP   (CP),
      .MRn  (MRn),
`ifdef TJ_SEQ_STEP_EN
      .step (step),
`endif
      .bus  (bus)
   );

   assign bus.pc_q     = pc;
   assign bus.rom_data = rom[bus.rom_addr];
   assign bus.zf       = zf;
   assign bus.cf       = cf;

   // Counter model: async clear, sync load (PEn low) wins over count
   always_ff @(posedge CP or negedge MRn) begin
      if (!MRn)                             pc <= 4'h0;
      else if (!bus.pc_pen)                 pc <= bus.pc_di;
      else if (bus.pc_cep && bus.pc_cet)    pc <= pc + 4'h1;
   end

   initial CP = 1'b0;
   always #5 CP = ~CP;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   // FETCH->EXEC edge; in step builds a one-cycle step pulse accompanies it
   task automatic tick_exec();
`ifdef TJ_SEQ_STEP_EN
      step = 1'b1;
`endif
      tick();
`ifdef TJ_SEQ_STEP_EN
      step = 1'b0;
`endif
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   // Assert reset at a falling edge, check outputs at once, release, then take the RST->FETCH edge
   task automatic do_reset();
      @(negedge CP);
      MRn = 1'b0;
      #1;
      chk("rst_pen",    8'(bus.pc_pen),   8'h1);
      chk("rst_cep",    8'(bus.pc_cep),   8'h0);
      chk("rst_cet",    8'(bus.pc_cet),   8'h1);
      chk("rst_di",     8'(bus.pc_di),    8'h0);
      chk("rst_we",     8'(bus.alu_we),   8'h0);
      chk("rst_op",     8'(bus.alu_op),   8'h0);
      chk("rst_halted", 8'(bus.halted),   8'h0);
      chk("rst_addr",   8'(bus.rom_addr), 8'h0);
      @(negedge CP);
      MRn = 1'b1;
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      MRn    = 1'b0;
      zf     = 1'b0;
      cf     = 1'b0;
`ifdef TJ_SEQ_STEP_EN
      step   = 1'b0;
`endif
      clear_rom();
      repeat (2) @(posedge CP);

      // Sequential NOPs through a full wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tick_exec();
         chk("nop_cep",  8'(bus.pc_cep), 8'h1);
         chk("nop_pen",  8'(bus.pc_pen), 8'h1);
         chk("nop_pc",   8'(bus.pc_q),   8'(i));
         tick();
         chk("nop_idle", 8'(bus.pc_cep), 8'h0);
      end
      chk("nop_wrap", 8'(bus.pc_q), 8'h0);

      // Reset taken while in EXEC at pc=2
      tick_exec(); tick(); tick_exec(); tick(); tick_exec();
      chk("pre_rst_pc", 8'(bus.pc_q), 8'h2);
      do_reset();
      tick_exec();
      chk("post_rst_pc",  8'(bus.pc_q),   8'h0);
      chk("post_rst_cep", 8'(bus.pc_cep), 8'h1);

      // JMP A, then JZ 5 taken
      clear_rom();
      rom[0]  = 8'h1A;
      rom[10] = 8'h25;
      zf = 1'b1;
      do_reset();
      tick_exec();
      chk("jmp_pen", 8'(bus.pc_pen), 8'h0);
      chk("jmp_cep", 8'(bus.pc_cep), 8'h0);
      chk("jmp_di",  8'(bus.pc_di),  8'hA);
      tick();
      chk("jmp_pc",     8'(bus.pc_q),  8'hA);
      chk("fetch_di",   8'(bus.pc_di), 8'h0);
      chk("fetch_pen",  8'(bus.pc_pen), 8'h1);
      tick_exec();
      chk("jz_pen", 8'(bus.pc_pen), 8'h0);
      chk("jz_di",  8'(bus.pc_di),  8'h5);
      tick();
      chk("jz_pc", 8'(bus.pc_q), 8'h5);

      // JNZ/JC fall through, then JZ E and JC 6 taken
      clear_rom();
      rom[0]  = 8'h37;
      rom[1]  = 8'h4C;
      rom[2]  = 8'h2E;
      rom[14] = 8'h46;
      zf = 1'b1;
      cf = 1'b0;
      do_reset();
      tick_exec();
      chk("jnz_ft_cep", 8'(bus.pc_cep), 8'h1);
      chk("jnz_ft_pen", 8'(bus.pc_pen), 8'h1);
      tick();
      chk("jnz_ft_pc", 8'(bus.pc_q), 8'h1);
      tick_exec();
      chk("jc_ft_cep", 8'(bus.pc_cep), 8'h1);
      chk("jc_ft_pen", 8'(bus.pc_pen), 8'h1);
      tick();
      chk("jc_ft_pc", 8'(bus.pc_q), 8'h2);
      tick_exec();
      chk("jz_tk_pen", 8'(bus.pc_pen), 8'h0);
      chk("jz_tk_cep", 8'(bus.pc_cep), 8'h0);
      tick();
      chk("jz_tk_pc", 8'(bus.pc_q), 8'hE);
      cf = 1'b1;
      tick_exec();
      chk("jc_tk_pen", 8'(bus.pc_pen), 8'h0);
      tick();
      chk("jc_tk_pc", 8'(bus.pc_q), 8'h6);

      // ALU strobe for opcode 9, immediate 3
      clear_rom();
      rom[0] = 8'h93;
      zf = 1'b0;
      cf = 1'b0;
      do_reset();
      chk("alu_pre_we", 8'(bus.alu_we), 8'h0);
      tick_exec();
      chk("alu_we",  8'(bus.alu_we),  8'h1);
      chk("alu_op",  8'(bus.alu_op),  8'h9);
      chk("alu_imm", 8'(bus.alu_imm), 8'h3);
      chk("alu_cep", 8'(bus.pc_cep),  8'h1);
      chk("alu_pen", 8'(bus.pc_pen),  8'h1);
      tick();
      chk("alu_we_off", 8'(bus.alu_we), 8'h0);
      chk("alu_op_off", 8'(bus.alu_op), 8'h0);
      chk("alu_pc",     8'(bus.pc_q),   8'h1);

      // HLT at address 2 freezes the PC until reset
      clear_rom();
      rom[2] = 8'h50;
      do_reset();
      tick_exec(); tick(); tick_exec(); tick();
      chk("hlt_pc_pre", 8'(bus.pc_q), 8'h2);
      tick_exec();
      chk("hlt_exec_halted", 8'(bus.halted), 8'h0);
      chk("hlt_exec_pen",    8'(bus.pc_pen), 8'h1);
      chk("hlt_exec_cep",    8'(bus.pc_cep), 8'h0);
      tick();
      chk("hlt_halted", 8'(bus.halted), 8'h1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hlt_hold_halted", 8'(bus.halted), 8'h1);
         chk("hlt_hold_pc",     8'(bus.pc_q),   8'h2);
      end
      do_reset();
      tick_exec();
      chk("hlt_clear_cep", 8'(bus.pc_cep), 8'h1);
      tick();
      chk("hlt_clear_pc", 8'(bus.pc_q), 8'h1);

`ifdef TJ_SEQ_STEP_EN
      // No step edges: nothing executes
      clear_rom();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("step_idle_cep", 8'(bus.pc_cep), 8'h0);
      end
      chk("step_idle_pc", 8'(bus.pc_q), 8'h0);
      // Three pulses, three instructions
      for (int i = 0; i < 3; i++) begin
         step = 1'b1; tick();
         step = 1'b0; tick();
         tick();
      end
      chk("step_pulse_pc", 8'(bus.pc_q), 8'h3);
      // Step held high yields exactly one instruction
      step = 1'b1;
      repeat (6) tick();
      chk("step_hold_pc", 8'(bus.pc_q), 8'h4);
      step = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
